jtdd_adpcm_arb: RTL and testbench
=================================

# jtdd_adpcm_arb

Two-way ROM arbiter for the Double Dragon sound board's two ADPCM channels. It shares one SDRAM ROM slot between the channel-0 and channel-1 sample fetchers. Each channel gets a one-entry read cache, so a repeated address is answered without a new SDRAM access. It sits between the two ADPCM decoders and the single ADPCM ROM port of the SDRAM controller.

## Interface
Parameters:
- AW, 16, per-channel byte address width; the ROM address is AW+1 bits wide.

Ports:
- clk  in  1  system clock, 24 MHz
- rst  in  1  reset; synchronous, active-high
- adpcm0_addr  in  AW  channel 0 byte address
- adpcm0_cs  in  1  channel 0 read request, level
- adpcm0_data  out  8  channel 0 read data (cache data)
- adpcm0_ok  out  1  channel 0 data valid for the current address
- adpcm1_addr, adpcm1_cs, adpcm1_data, adpcm1_ok: same as channel 0, for channel 1
- rom_addr  out  AW+1  {channel, address} to the SDRAM slot; channel 1 uses the upper half
- rom_cs  out  1  SDRAM read request
- rom_data  in  8  SDRAM read data
- rom_ok  in  1  SDRAM data valid

## Operation
Per-channel cache state:
- caddr[AW-1:0], cdata[7:0], cvalid.
- hitN = csN & cvalidN & (addrN == caddrN), combinational.
- adpcmN_ok = hitN; adpcmN_data = cdataN at all times.
- pendN = csN & ~hitN.

FSM states are IDLE, GUARD and WAIT:
- IDLE:
  - If any pendN, select a channel: if only one is pending, take it; if both are pending, take the channel not served last (round-robin pointer `last`).
  - Register sel, reqaddr <= addr_sel, rom_addr <= {sel, addr_sel}, rom_cs <= 1, then go to GUARD.
- GUARD: one cycle. rom_ok is ignored here (the SDRAM ok may be stale after an address change). Go to WAIT.
- WAIT:
  - Hold rom_cs and rom_addr until rom_ok = 1.
  - On rom_ok: caddr_sel <= reqaddr, cdata_sel <= rom_data, cvalid_sel <= 1, rom_cs <= 0, last <= sel, go to IDLE.
  - No timeout.

Rules:
- A fetch, once issued, always completes and fills the cache with the captured address, even if the requester changes its address or drops cs meanwhile. A changed address then misses and issues a new fetch.
- The non-selected channel waits. Its ok stays driven by its own cache, so hits on the other channel are served during a fetch.
- The cache of the channel being filled changes only on the completion edge. Its ok may therefore be high (old address hit) during the fetch only if its address still equals caddr.
- rom_addr holds its last value while idle.
- cs low: ok low, and no request is issued.

## Timing
Reset values:
- state IDLE, rom_cs 0, rom_addr 0, cvalid0/1 0, caddr/cdata 0.
- last = 1, so channel 0 wins the first tie.
- adpcmN_ok 0, adpcmN_data 0.

Reset mid-fetch aborts it: rom_cs drops and the caches are invalidated on that clock edge.

Latency, with pendN true in IDLE at cycle T:
- rom_cs = 1 from cycle T+1 (GUARD).
- WAIT from T+2; rom_ok is sampled from T+2.
- If rom_ok is high in cycle M ≥ T+2: in cycle M+1 adpcmN_ok = 1, data is valid, rom_cs = 0, state is IDLE.
- The minimum is 3 cycles from request to ok.
- The next fetch's rom_cs rises at M+2 at the earliest, so there is one idle cycle between fetches.

An address change on a hit drops ok in the same cycle, combinationally.

## Test plan
- Reset, then adpcm0_cs=1 with addr 0x1234 held; SDRAM returns 0xA5 with rom_ok two cycles after rom_cs rises -> rom_addr=0x01234, rom_cs high for 3 cycles, adpcm0_ok=1 with data 0xA5 one cycle after rom_ok, no second fetch while addr is unchanged.
- Both channels request new addresses in the same cycle (0x0010, 0x0020) after reset -> channel 0 is fetched first (rom_addr 0x00010), then channel 1 (0x10020); both oks end high.
- Continuous misses on both channels -> fetches strictly alternate 0,1,0,1; neither channel is served twice in a row while the other is pending.
- Channel 0 changes its address from 0x0100 to 0x0101 during WAIT -> the first fetch completes to 0x0100 (ok stays low because the address no longer matches), then a new fetch to 0x0101 follows and ok rises with the new data.
- rom_ok held high permanently (stale) -> the GUARD cycle is enforced: data is captured no earlier than the second rom_cs cycle and ok rises exactly 3 cycles after the request.
- rst asserted during WAIT -> rom_cs=0 and both oks 0 on the next cycle; a previously cached address misses after reset and is refetched.

Source files
------------

// File: rtl/jtdd_adpcm_arb_if.sv
// ---------------------------------------------------------------------------
// jtdd_adpcm_arb_if
// Bundle of every bus signal around the Double Dragon ADPCM ROM arbiter.
// One side holds the two ADPCM sample fetchers and the SDRAM ROM slot; the
// other side is the arbiter itself.
//
// Signals:
//   adpcm0_addr/adpcm1_addr  AW     channel byte address (fetcher -> arbiter)
//   adpcm0_cs/adpcm1_cs      1      channel read request, level
//   adpcm0_data/adpcm1_data  8      channel read data (arbiter -> fetcher)
//   adpcm0_ok/adpcm1_ok      1      data valid for the current address
//   rom_addr                 AW+1   {channel, address} to the SDRAM slot
//   rom_cs                   1      SDRAM read request
//   rom_data                 8      SDRAM read data
//   rom_ok                   1      SDRAM data valid
//
// Modports:
//   master  environment side (fetchers + SDRAM controller)
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface jtdd_adpcm_arb_if #(
  parameter int AW = 16
);
  logic [AW-1:0] adpcm0_addr;
  logic          adpcm0_cs;
  logic [7:0]    adpcm0_data;
  logic          adpcm0_ok;

  logic [AW-1:0] adpcm1_addr;
  logic          adpcm1_cs;
  logic [7:0]    adpcm1_data;
  logic          adpcm1_ok;

  logic [AW:0]   rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (
    output adpcm0_addr, adpcm0_cs, adpcm1_addr, adpcm1_cs,
    input  adpcm0_data, adpcm0_ok, adpcm1_data, adpcm1_ok,
    input  rom_addr, rom_cs,
    output rom_data, rom_ok
  );

  modport slave (
    input  adpcm0_addr, adpcm0_cs, adpcm1_addr, adpcm1_cs,
    output adpcm0_data, adpcm0_ok, adpcm1_data, adpcm1_ok,
    output rom_addr, rom_cs,
    input  rom_data, rom_ok
  );
endinterface

// File: rtl/jtdd_adpcm_arb.sv
// ---------------------------------------------------------------------------
// jtdd_adpcm_arb
// Shares one SDRAM ROM slot between the two ADPCM channels of the Double
// Dragon sound board. Each channel owns a one-entry read cache, so a repeated
// address is answered straight from the cache without touching the SDRAM.
// When both channels miss at the same time the channel that was not served
// last goes first.
//
// Ports:
//   clk  in  1   system clock (24 MHz)
//   rst  in  1   synchronous active-high reset
//   bus  jtdd_adpcm_arb_if.slave
//        adpcmN_addr/cs in, adpcmN_data/ok out,
//        rom_addr/rom_cs out, rom_data/rom_ok in
//
// Parameters:
//   AW   per-channel byte address width; rom_addr is AW+1 bits
// ---------------------------------------------------------------------------
module jtdd_adpcm_arb #(
  parameter int AW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  jtdd_adpcm_arb_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [AW-1:0] r_cAddr0;
  logic [AW-1:0] r_cAddr1;
  logic [7:0]    r_cData0;
  logic [7:0]    r_cData1;
  logic          r_cValid0;
  logic          r_cValid1;

  logic          r_sel;
  logic          r_last;
  logic [AW-1:0] r_reqAddr;
  logic [AW:0]   r_romAddr;
  logic          r_romCs;

  logic          w_hit0;
  logic          w_hit1;
  logic          w_pend0;
  logic          w_pend1;
  logic          w_issue;
  logic          w_fill;
  logic          w_pickSel;
  logic [AW-1:0] w_pickAddr;

  // Hits are purely combinational so an address change drops ok at once.
  assign w_hit0  = bus.adpcm0_cs & r_cValid0 & (bus.adpcm0_addr == r_cAddr0);
  assign w_hit1  = bus.adpcm1_cs & r_cValid1 & (bus.adpcm1_addr == r_cAddr1);
  assign w_pend0 = bus.adpcm0_cs & ~w_hit0;
  assign w_pend1 = bus.adpcm1_cs & ~w_hit1;

  assign bus.adpcm0_ok   = w_hit0;
  assign bus.adpcm1_ok   = w_hit1;
  assign bus.adpcm0_data = r_cData0;
  assign bus.adpcm1_data = r_cData1;
  assign bus.rom_addr    = r_romAddr;
  assign bus.rom_cs      = r_romCs;

  assign w_pickAddr = w_pickSel ? bus.adpcm1_addr : bus.adpcm0_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the issue/fill strobes. A tie goes to the channel that
  // was not served last. GUARD deliberately ignores rom_ok, since the SDRAM
  // ok can still be high from the previous address for one cycle.
  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_fill      = 1'b0;
    w_pickSel   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pend0 | w_pend1) begin
          w_issue     = 1'b1;
          w_nextState = GUARD;
          if (w_pend0 & w_pend1) begin
            w_pickSel = ~r_last;
          end else begin
            w_pickSel = w_pend1;
          end
        end
      end
      GUARD: begin
        w_nextState = WAIT;
      end
      WAIT: begin
        if (bus.rom_ok) begin
          w_fill      = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request and cache registers. The fill always uses the address latched at
  // issue time, so a requester that moved on simply misses afterwards and
  // triggers a fresh fetch. rom_addr keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_reqAddr <= '0;
      r_romAddr <= '0;
      r_romCs   <= 1'b0;
      r_cAddr0  <= '0;
      r_cAddr1  <= '0;
      r_cData0  <= 8'd0;
      r_cData1  <= 8'd0;
      r_cValid0 <= 1'b0;
      r_cValid1 <= 1'b0;
    end else begin
      if (w_issue) begin
        r_sel     <= w_pickSel;
        r_reqAddr <= w_pickAddr;
        r_romAddr <= {w_pickSel, w_pickAddr};
        r_romCs   <= 1'b1;
      end
      if (w_fill) begin
        r_romCs <= 1'b0;
        r_last  <= r_sel;
        if (r_sel) begin
          r_cAddr1  <= r_reqAddr;
          r_cData1  <= bus.rom_data;
          r_cValid1 <= 1'b1;
        end else begin
          r_cAddr0  <= r_reqAddr;
          r_cData0  <= bus.rom_data;
          r_cValid0 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtdd_adpcm_arb.sv
// ---------------------------------------------------------------------------
// tb_jtdd_adpcm_arb
// Bench for the ADPCM ROM arbiter: a table of hand-derived cycle vectors,
// directed sequences for the multi-cycle corner cases, and a random run
// checked against a transaction-level model of the two caches and the
// single outstanding SDRAM fetch.
// ---------------------------------------------------------------------------
module tb_jtdd_adpcm_arb;

  localparam int AW = 16;

  typedef struct {
    logic          rst;
    logic          cs0;
    logic [AW-1:0] addr0;
    logic          cs1;
    logic [AW-1:0] addr1;
    logic          romOk;
    logic [7:0]    romData;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic          ok0;
    logic [7:0]    data0;
    logic          ok1;
    logic [7:0]    data1;
    logic          romCs;
    logic [AW:0]   romAddr;
  } vec_t;

  typedef struct {
    bit            valid;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } line_t;

  logic clk;
  logic rst;

  jtdd_adpcm_arb_if #(.AW(AW)) bus();

  jtdd_adpcm_arb #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;

  stim_t cur;
  vec_t  tableVec;
  int    curRow;

  // Reference model: two cache lines plus at most one fetch in flight,
  // tracked by its age in cycles since it was issued.
  line_t         mCache[2];
  bit            mBusy;
  int            mAge;
  bit            mCh;
  logic [AW-1:0] mAddr;
  bit            mLast;
  logic [AW:0]   mRomAddr;

  logic [AW:0]   fetchLog[$];
  logic          prevRomCs;
  logic          obsOk0[$];
  logic          obsOk1[$];
  logic          obsRomCs[$];
  logic [7:0]    obsData0[$];

  vec_t vecs[15];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.rst     = 1'b0;
    s.cs0     = 1'b0;
    s.addr0   = '0;
    s.cs1     = 1'b0;
    s.addr1   = '0;
    s.romOk   = 1'b0;
    s.romData = 8'h00;
    return s;
  endfunction

  function automatic vec_t mk(input logic r, input logic cs0, input logic [AW-1:0] a0,
                              input logic ok, input logic [7:0] rd, input logic eOk0,
                              input logic [7:0] eData0, input logic eCs, input logic [AW:0] eAddr);
    vec_t v;
    v.s         = idleStim();
    v.s.rst     = r;
    v.s.cs0     = cs0;
    v.s.addr0   = a0;
    v.s.romOk   = ok;
    v.s.romData = rd;
    v.ok0       = eOk0;
    v.data0     = eData0;
    v.ok1       = 1'b0;
    v.data1     = 8'h00;
    v.romCs     = eCs;
    v.romAddr   = eAddr;
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mCache[i].valid = 1'b0;
      mCache[i].addr  = '0;
      mCache[i].data  = 8'h00;
    end
    mBusy    = 1'b0;
    mAge     = 0;
    mCh      = 1'b0;
    mAddr    = '0;
    mLast    = 1'b1;
    mRomAddr = '0;
  endtask

  function automatic bit modelHit(input int ch);
    if (ch == 0) return cur.cs0 && mCache[0].valid && (mCache[0].addr == cur.addr0);
    return cur.cs1 && mCache[1].valid && (mCache[1].addr == cur.addr1);
  endfunction

  // Advance the model by one clock using the inputs of the current cycle.
  task automatic modelAdvance();
    bit p0;
    bit p1;
    if (cur.rst) begin
      modelReset();
      return;
    end
    if (mBusy) begin
      if (mAge >= 1 && cur.romOk) begin
        mCache[mCh].valid = 1'b1;
        mCache[mCh].addr  = mAddr;
        mCache[mCh].data  = cur.romData;
        mBusy = 1'b0;
        mLast = mCh;
      end else begin
        mAge++;
      end
    end else begin
      p0 = cur.cs0 && !modelHit(0);
      p1 = cur.cs1 && !modelHit(1);
      if (p0 || p1) begin
        mCh      = (p0 && p1) ? !mLast : p1;
        mAddr    = mCh ? cur.addr1 : cur.addr0;
        mRomAddr = {mCh, mAddr};
        mBusy    = 1'b1;
        mAge     = 0;
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst             = s.rst;
    bus.adpcm0_cs   = s.cs0;
    bus.adpcm0_addr = s.addr0;
    bus.adpcm1_cs   = s.cs1;
    bus.adpcm1_addr = s.addr1;
    bus.rom_ok      = s.romOk;
    bus.rom_data    = s.romData;
  endtask

  // mode 0: observe only, 1: compare against tableVec, 2: compare against model
  task automatic checkOutput(input int mode);
    if (bus.rom_cs === 1'b1 && prevRomCs !== 1'b1) fetchLog.push_back(bus.rom_addr);
    prevRomCs = bus.rom_cs;
    obsOk0.push_back(bus.adpcm0_ok);
    obsOk1.push_back(bus.adpcm1_ok);
    obsRomCs.push_back(bus.rom_cs);
    obsData0.push_back(bus.adpcm0_data);
    if (mode == 1) begin
      cmp($sformatf("row%0d ok0", curRow),     32'(bus.adpcm0_ok),   32'(tableVec.ok0));
      cmp($sformatf("row%0d data0", curRow),   32'(bus.adpcm0_data), 32'(tableVec.data0));
      cmp($sformatf("row%0d ok1", curRow),     32'(bus.adpcm1_ok),   32'(tableVec.ok1));
      cmp($sformatf("row%0d data1", curRow),   32'(bus.adpcm1_data), 32'(tableVec.data1));
      cmp($sformatf("row%0d rom_cs", curRow),  32'(bus.rom_cs),      32'(tableVec.romCs));
      cmp($sformatf("row%0d rom_addr", curRow),32'(bus.rom_addr),    32'(tableVec.romAddr));
    end else if (mode == 2) begin
      cmp("model ok0",      32'(bus.adpcm0_ok),   32'(modelHit(0)));
      cmp("model data0",    32'(bus.adpcm0_data), 32'(mCache[0].data));
      cmp("model ok1",      32'(bus.adpcm1_ok),   32'(modelHit(1)));
      cmp("model data1",    32'(bus.adpcm1_data), 32'(mCache[1].data));
      cmp("model rom_cs",   32'(bus.rom_cs),      32'(mBusy));
      cmp("model rom_addr", 32'(bus.rom_addr),    32'(mRomAddr));
    end
    modelAdvance();
  endtask

  task automatic step(input int mode);
    applyStimulus(cur);
    @(negedge clk);
    checkOutput(mode);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    cur     = idleStim();
    cur.rst = 1'b1;
    step(2);
    cur.rst = 1'b0;
    fetchLog.delete();
    obsOk0.delete();
    obsOk1.delete();
    obsRomCs.delete();
    obsData0.delete();
  endtask

  initial begin
    logic [31:0] r;

    modelReset();
    prevRomCs = 1'b0;
    cur       = idleStim();
    cur.rst   = 1'b1;
    step(0);
    step(0);

    // Single channel-0 fetch of 0x1234, rom_ok two cycles after rom_cs rises.
    vecs[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 17'h00000);
    vecs[1]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 17'h00000);
    vecs[2]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 17'h01234);
    vecs[3]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 17'h01234);
    vecs[4]  = mk(1'b0, 1'b1, 16'h1234, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 17'h01234);
    vecs[5]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 17'h01234);
    vecs[6]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 17'h01234);
    vecs[7]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 17'h01234);
    vecs[8]  = mk(1'b0, 1'b0, 16'h1234, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 17'h01234);
    vecs[9]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 17'h01234);
    vecs[10] = mk(1'b0, 1'b1, 16'h1235, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 17'h01234);
    vecs[11] = mk(1'b0, 1'b1, 16'h1235, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 17'h01235);
    vecs[12] = mk(1'b0, 1'b1, 16'h1235, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 17'h01235);
    vecs[13] = mk(1'b0, 1'b1, 16'h1235, 1'b1, 8'h3C, 1'b0, 8'hA5, 1'b1, 17'h01235);
    vecs[14] = mk(1'b0, 1'b1, 16'h1235, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 17'h01235);

    for (int i = 0; i < 15; i++) begin
      curRow   = i;
      tableVec = vecs[i];
      cur      = vecs[i].s;
      step(1);
    end

    // Simultaneous misses after reset: channel 0 first, then channel 1.
    doReset();
    cur.cs0 = 1'b1; cur.addr0 = 16'h0010;
    cur.cs1 = 1'b1; cur.addr1 = 16'h0020;
    for (int k = 0; k < 12; k++) begin
      cur.romOk   = 1'b1;
      cur.romData = 8'h40 + 8'(k);
      step(2);
    end
    cmp("tie fetch count", 32'(fetchLog.size()), 32'd2);
    if (fetchLog.size() >= 2) begin
      cmp("tie first addr",  32'(fetchLog[0]), 32'h00010);
      cmp("tie second addr", 32'(fetchLog[1]), 32'h10020);
    end
    cmp("tie ok0 end", 32'(bus.adpcm0_ok), 32'd1);
    cmp("tie ok1 end", 32'(bus.adpcm1_ok), 32'd1);

    // Continuous misses on both channels: strict alternation 0,1,0,1...
    doReset();
    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      cur.cs0   = 1'b1; cur.addr0 = 16'h0200 + 16'(k);
      cur.cs1   = 1'b1; cur.addr1 = 16'h0300 + 16'(k);
      cur.romOk = r[0];
      cur.romData = r[15:8];
      step(2);
    end
    cmp("alternate enough fetches", 32'(fetchLog.size() >= 4), 32'd1);
    for (int i = 0; i < fetchLog.size(); i++) begin
      cmp($sformatf("alternate fetch%0d channel", i), 32'(fetchLog[i][AW]), 32'(i % 2));
    end

    // Address change during WAIT: stale fill, then refetch of the new address.
    doReset();
    cur.cs0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cur.addr0   = (k < 3) ? 16'h0100 : 16'h0101;
      cur.romOk   = (k == 4 || k == 9);
      cur.romData = (k == 4) ? 8'h11 : ((k == 9) ? 8'h22 : 8'h00);
      step(2);
    end
    cmp("addr change fetch count", 32'(fetchLog.size()), 32'd2);
    if (fetchLog.size() >= 2) begin
      cmp("addr change first",  32'(fetchLog[0]), 32'h00100);
      cmp("addr change second", 32'(fetchLog[1]), 32'h00101);
    end
    cmp("addr change stale ok0", 32'(obsOk0[5]), 32'd0);
    cmp("addr change final ok0", 32'(bus.adpcm0_ok), 32'd1);
    cmp("addr change final data0", 32'(bus.adpcm0_data), 32'h22);

    // rom_ok stuck high: GUARD must skip the stale ok.
    doReset();
    cur.cs0 = 1'b1; cur.addr0 = 16'h0777;
    for (int k = 0; k < 6; k++) begin
      cur.romOk   = 1'b1;
      cur.romData = 8'h50 + 8'(k);
      step(2);
    end
    cmp("stale ok0 at +2", 32'(obsOk0[2]), 32'd0);
    cmp("stale ok0 at +3", 32'(obsOk0[3]), 32'd1);
    cmp("stale data0 at +3", 32'(obsData0[3]), 32'h52);

    // Reset during WAIT aborts the fetch and invalidates the caches.
    doReset();
    cur.cs0 = 1'b1; cur.addr0 = 16'h0ABC;
    for (int k = 0; k < 5; k++) begin
      cur.romOk = 1'b1; cur.romData = 8'h77;
      step(2);
    end
    cmp("pre-reset ok0", 32'(bus.adpcm0_ok), 32'd1);
    cur.cs1 = 1'b1; cur.addr1 = 16'h0DEF; cur.romOk = 1'b0;
    for (int k = 0; k < 3; k++) step(2);
    cmp("pre-reset rom_cs", 32'(bus.rom_cs), 32'd1);
    cur.rst = 1'b1;
    step(2);
    cur.rst = 1'b0;
    fetchLog.delete(); obsOk0.delete(); obsOk1.delete(); obsRomCs.delete();
    for (int k = 0; k < 6; k++) begin
      cur.romOk = (k >= 1); cur.romData = 8'h99;
      step(2);
    end
    cmp("post-reset rom_cs", 32'(obsRomCs[0]), 32'd0);
    cmp("post-reset ok0",    32'(obsOk0[0]),   32'd0);
    cmp("post-reset ok1",    32'(obsOk1[0]),   32'd0);
    cmp("post-reset refetch present", 32'(fetchLog.size() >= 1), 32'd1);
    if (fetchLog.size() >= 1) cmp("post-reset refetch addr", 32'(fetchLog[0]), 32'h00ABC);

    // Random traffic against the model.
    doReset();
    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      cur.rst     = (r[31:23] == 9'd0);
      cur.romOk   = (r[9:8] != 2'b00);
      cur.romData = r[7:0];
      cur.cs0     = (r[13:10] != 4'd0);
      if (r[15:14] == 2'b00) cur.addr0 = {14'd0, r[17:16]};
      cur.cs1     = (r[21:18] != 4'd0);
      if (r[23:22] == 2'b00) cur.addr1 = {14'd0, r[17:16] ^ r[1:0]};
      step(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
